segment_uop_pipeliner: RTL and testbench

- Successor to the single-outstanding segment sequencer. Splits one segmented vector load/store (NFIELDS = nf+1 fields, 1..8) into per-field, per-segment micro-ops for Ara's backend.
- Allows up to MaxOutstanding micro-ops in flight instead of waiting for each response before issuing the next.
- Sits between the frontend dispatcher and the backend request/response path. Tracks the faulting segment precisely and reports final completion only once Ara is idle.

---
 rtl/segment_uop_pipeliner.sv | 235 +++++++++++++++++++++++
 tb/tb_segment_uop_pipeliner.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_uop_pipeliner.sv
// -----------------------------------------------------------------------------
// segment_uop_pipeliner
//
// Purpose: splits one segmented vector load/store (nf+1 fields, vl segments,
// starting at vstart) into per-field, per-segment micro-ops. Up to
// MaxOutstanding micro-ops may be in flight. Their segment indices are held in
// a small in-order FIFO so that the faulting segment of the first excepting
// response can be reported precisely. Completion is reported only once the
// backend is idle.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   ara_idle_i              backend fully idle
//   seg_*                   request from the dispatcher (valid/ready handshake)
//   uop_*                   micro-op to the backend (valid/ready handshake)
//   resp_valid_i/resp_exc_i one in-order response per issued micro-op
//   done_*                  one-cycle completion pulse with exception info
//   load_/store_complete_o  completion pulse qualified by op type
//   busy_o                  an operation is in progress
//
// Optional feature (macro SEG_UOP_PERF_CNT_EN):
//   perf_uops_o   saturating count of issued micro-ops
//   perf_stall_o  saturating count of ISSUE cycles with the window full
// -----------------------------------------------------------------------------
module segment_uop_pipeliner #(
   parameter int unsigned NfWidth        = 3,
   parameter int unsigned VlWidth        = 16,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               ara_idle_i,
   input  logic               seg_valid_i,
   output logic               seg_ready_o,
   input  logic [NfWidth-1:0] seg_nf_i,
   input  logic [VlWidth-1:0] seg_vl_i,
   input  logic [VlWidth-1:0] seg_vstart_i,
   input  logic [4:0]         seg_vd_i,
   input  logic               seg_is_load_i,
   output logic               uop_valid_o,
   input  logic               uop_ready_i,
   output logic [VlWidth-1:0] uop_vstart_o,
   output logic [VlWidth-1:0] uop_vl_o,
   output logic [4:0]         uop_vd_o,
   input  logic               resp_valid_i,
   input  logic               resp_exc_i,
   output logic               done_valid_o,
   output logic               done_exc_o,
   output logic [VlWidth-1:0] done_vstart_o,
   output logic               load_complete_o,
   output logic               store_complete_o,
   output logic               busy_o
`ifdef SEG_UOP_PERF_CNT_EN
   ,
   output logic [31:0]        perf_uops_o,
   output logic [31:0]        perf_stall_o
`endif
);

   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_IDLE} state_e;

   state_e             state_q;
   logic [NfWidth-1:0] nf_q, f_q;
   logic [VlWidth-1:0] vl_q, s_q, fault_q;
   logic [4:0]         vd_q;
   logic               is_load_q, exc_q;
   logic [CntW-1:0]    outstanding_q, outstanding_d;
   logic [VlWidth-1:0] fifo_q [MaxOutstanding];
   logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
   logic               done_valid_q, done_exc_q, load_complete_q, store_complete_q;
   logic [VlWidth-1:0] done_vstart_q;

   logic               seg_fire, uop_fire, resp_pop, exc_hit, last_uop;
   logic [VlWidth:0]   s_plus1;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // One extra bit so that vl = 2^VlWidth-1 still compares correctly.
   assign s_plus1  = {1'b0, s_q} + (VlWidth+1)'(1);
   // Responses with nothing outstanding are protocol errors and are dropped.
   assign resp_pop = resp_valid_i && (outstanding_q != '0);
   // Only the first exception counts; later flags are drained silently.
   assign exc_hit  = resp_pop && resp_exc_i && !exc_q;
   assign last_uop = (f_q == nf_q) && (s_plus1 == {1'b0, vl_q});

   // Issue stops in the very cycle the first exception arrives.
   assign uop_valid_o   = (state_q == ISSUE) && (outstanding_q < MaxCnt) && !exc_hit;
   assign uop_fire      = uop_valid_o && uop_ready_i;
   assign uop_vstart_o  = s_q;
   assign uop_vl_o      = s_plus1[VlWidth-1:0];
   assign uop_vd_o      = vd_q + 5'(f_q);

   // Held low during the done pulse so a new op starts the cycle after it.
   assign seg_ready_o   = (state_q == IDLE) && !done_valid_q;
   assign seg_fire      = seg_valid_i && seg_ready_o;
   assign busy_o        = (state_q != IDLE);

   assign outstanding_d = outstanding_q + CntW'(uop_fire) - CntW'(resp_pop);

   assign done_valid_o     = done_valid_q;
   assign done_exc_o       = done_exc_q;
   assign done_vstart_o    = done_vstart_q;
   assign load_complete_o  = load_complete_q;
   assign store_complete_o = store_complete_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= IDLE;
         nf_q             <= '0;
         f_q              <= '0;
         vl_q             <= '0;
         s_q              <= '0;
         fault_q          <= '0;
         vd_q             <= '0;
         is_load_q        <= 1'b0;
         exc_q            <= 1'b0;
         outstanding_q    <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         done_valid_q     <= 1'b0;
         done_exc_q       <= 1'b0;
         done_vstart_q    <= '0;
         load_complete_q  <= 1'b0;
         store_complete_q <= 1'b0;
         for (int i = 0; i < int'(MaxOutstanding); i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         done_valid_q     <= 1'b0;
         done_exc_q       <= 1'b0;
         done_vstart_q    <= '0;
         load_complete_q  <= 1'b0;
         store_complete_q <= 1'b0;
         outstanding_q    <= outstanding_d;

         // Segment-index FIFO: push on issue, pop on response.
         if (uop_fire) begin
            fifo_q[wr_ptr_q] <= s_q;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (resp_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (exc_hit) begin
            exc_q   <= 1'b1;
            fault_q <= fifo_q[rd_ptr_q];
         end

         unique case (state_q)
            IDLE: begin
               if (seg_fire) begin
                  nf_q      <= seg_nf_i;
                  vl_q      <= seg_vl_i;
                  vd_q      <= seg_vd_i;
                  is_load_q <= seg_is_load_i;
                  f_q       <= '0;
                  s_q       <= seg_vstart_i;
                  exc_q     <= 1'b0;
                  fault_q   <= '0;
                  state_q   <= (seg_vstart_i >= seg_vl_i) ? WAIT_IDLE : ISSUE;
               end
            end
            ISSUE: begin
               if (exc_hit) begin
                  state_q <= DRAIN;
               end else if (uop_fire) begin
                  if (last_uop) begin
                     state_q <= DRAIN;
                  end
                  // Field index runs fastest, then the segment index.
                  if (f_q == nf_q) begin
                     f_q <= '0;
                     s_q <= s_plus1[VlWidth-1:0];
                  end else begin
                     f_q <= f_q + NfWidth'(1);
                  end
               end
            end
            DRAIN: begin
               if (outstanding_d == '0) begin
                  state_q <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               if (ara_idle_i) begin
                  state_q          <= IDLE;
                  done_valid_q     <= 1'b1;
                  done_exc_q       <= exc_q;
                  done_vstart_q    <= exc_q ? fault_q : vl_q;
                  load_complete_q  <= is_load_q;
                  store_complete_q <= !is_load_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SEG_UOP_PERF_CNT_EN
   logic [31:0] perf_uops_q, perf_stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_uops_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (uop_fire && (perf_uops_q != '1)) begin
            perf_uops_q <= perf_uops_q + 32'd1;
         end
         if ((state_q == ISSUE) && (outstanding_q == MaxCnt) && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_uops_o  = perf_uops_q;
   assign perf_stall_o = perf_stall_q;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(resp_valid_i && (outstanding_q == '0)))
            else $error("segment_uop_pipeliner: response with no micro-op outstanding");
      end
   end
`endif

endmodule

// File: tb/tb_segment_uop_pipeliner.sv
module tb_segment_uop_pipeliner;

   localparam int NfW = 3;
   localparam int VlW = 16;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   logic           ara_idle_i;
   logic           seg_valid_i;
   logic           seg_ready_o;
   logic [NfW-1:0] seg_nf_i;
   logic [VlW-1:0] seg_vl_i;
   logic [VlW-1:0] seg_vstart_i;
   logic [4:0]     seg_vd_i;
   logic           seg_is_load_i;
   logic           uop_valid_o;
   logic           uop_ready_i;
   logic [VlW-1:0] uop_vstart_o;
   logic [VlW-1:0] uop_vl_o;
   logic [4:0]     uop_vd_o;
   logic           resp_valid_i;
   logic           resp_exc_i;
   logic           done_valid_o;
   logic           done_exc_o;
   logic [VlW-1:0] done_vstart_o;
   logic           load_complete_o;
   logic           store_complete_o;
   logic           busy_o;
`ifdef SEG_UOP_PERF_CNT_EN
   logic [31:0]    perf_uops_o;
   logic [31:0]    perf_stall_o;
`endif

   segment_uop_pipeliner #(
      .NfWidth(NfW), .VlWidth(VlW), .MaxOutstanding(4)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .ara_idle_i(ara_idle_i),
      .seg_valid_i(seg_valid_i), .seg_ready_o(seg_ready_o),
      .seg_nf_i(seg_nf_i), .seg_vl_i(seg_vl_i), .seg_vstart_i(seg_vstart_i),
      .seg_vd_i(seg_vd_i), .seg_is_load_i(seg_is_load_i),
      .uop_valid_o(uop_valid_o), .uop_ready_i(uop_ready_i),
      .uop_vstart_o(uop_vstart_o), .uop_vl_o(uop_vl_o), .uop_vd_o(uop_vd_o),
      .resp_valid_i(resp_valid_i), .resp_exc_i(resp_exc_i),
      .done_valid_o(done_valid_o), .done_exc_o(done_exc_o),
      .done_vstart_o(done_vstart_o), .load_complete_o(load_complete_o),
      .store_complete_o(store_complete_o), .busy_o(busy_o)
`ifdef SEG_UOP_PERF_CNT_EN
      , .perf_uops_o(perf_uops_o), .perf_stall_o(perf_stall_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int nf;
      int vl;
      int vstart;
      int vd;
      bit is_load;
      int exc_idx;     // response index carrying the exception, -1 for none
      int idle_min;    // cycles before ara_idle_i may rise
      int exp_uops;    // expected micro-op count, -1 when ended by exception
      bit exp_exc;
      int exp_vstart;
   } vec_t;

   vec_t vecs[7];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic start_op(input int nf, input int vl, input int vstart, input int vd,
                           input bit is_load);
      @(negedge clk_i);
      chk("ready_before_accept", seg_ready_o, 1);
      seg_valid_i   = 1'b1;
      seg_nf_i      = NfW'(nf);
      seg_vl_i      = VlW'(vl);
      seg_vstart_i  = VlW'(vstart);
      seg_vd_i      = 5'(vd);
      seg_is_load_i = is_load;
   endtask

   // Runs one op with ready held high and responses returned two cycles
   // after issue; checks every micro-op and the completion pulse.
   task automatic run_op(input vec_t v, input int idx);
      int pend[$];
      int fired, resp_n, exc_cyc, after_exc, exp_s, exp_f, exp_total;
      bit done_seen;
      exp_total = (v.vstart < v.vl) ? (v.vl - v.vstart) * (v.nf + 1) : 0;
      start_op(v.nf, v.vl, v.vstart, v.vd, v.is_load);
      uop_ready_i = 1'b1;
      fired = 0; resp_n = 0; exc_cyc = -1; after_exc = 0; done_seen = 0;
      for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
         @(negedge clk_i);
         seg_valid_i  = 1'b0;
         resp_valid_i = 1'b0;
         resp_exc_i   = 1'b0;
         if (pend.size() > 0 && pend[0] + 2 <= cyc) begin
            void'(pend.pop_front());
            resp_valid_i = 1'b1;
            resp_exc_i   = (resp_n == v.exc_idx);
            if (resp_exc_i) exc_cyc = cyc;
            resp_n++;
         end
         ara_idle_i = (pend.size() == 0) && (cyc >= v.idle_min);
         #1;
         if (uop_valid_o && uop_ready_i) begin
            if (exc_cyc >= 0) after_exc++;
            if (fired < exp_total) begin
               exp_s = v.vstart + fired / (v.nf + 1);
               exp_f = fired % (v.nf + 1);
               chk("uop_vstart", uop_vstart_o, exp_s);
               chk("uop_vl", uop_vl_o, exp_s + 1);
               chk("uop_vd", uop_vd_o, (v.vd + exp_f) % 32);
            end
            pend.push_back(cyc);
            fired++;
         end
         if (done_valid_o) begin
            done_seen = 1;
            chk("done_after_idle", cyc > v.idle_min, 1);
            chk("done_exc", done_exc_o, v.exp_exc);
            chk("done_vstart", done_vstart_o, v.exp_vstart);
            chk("load_complete", load_complete_o, v.is_load);
            chk("store_complete", store_complete_o, !v.is_load);
            chk("ready_during_done", seg_ready_o, 0);
         end
      end
      chk("done_seen", done_seen, 1);
      if (v.exp_uops >= 0) chk("uop_count", fired, v.exp_uops);
      else                 chk("issue_after_exc", after_exc, 0);
      @(negedge clk_i);
      resp_valid_i = 1'b0;
      #1;
      chk("done_one_cycle", done_valid_o, 0);
      chk("ready_after_done", seg_ready_o, 1);
      chk("idle_after_done", busy_o, 0);
      $display("vector %0d: nf=%0d vl=%0d vstart=%0d vd=%0d load=%0d -> uops=%0d exc=%0d vstart=%0d",
               idx, v.nf, v.vl, v.vstart, v.vd, v.is_load, fired, v.exp_exc, v.exp_vstart);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_seg_ready", seg_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_uop_valid", uop_valid_o, 0);
      chk("rst_uop_vstart", uop_vstart_o, 0);
      chk("rst_uop_vd", uop_vd_o, 0);
      chk("rst_done_valid", done_valid_o, 0);
      chk("rst_done_exc", done_exc_o, 0);
      chk("rst_done_vstart", done_vstart_o, 0);
      chk("rst_load_complete", load_complete_o, 0);
      chk("rst_store_complete", store_complete_o, 0);
   endtask

   initial begin
      int fires, done_cnt;
      rst_ni = 1'b0; ara_idle_i = 1'b0; seg_valid_i = 1'b0; seg_nf_i = '0;
      seg_vl_i = '0; seg_vstart_i = '0; seg_vd_i = '0; seg_is_load_i = 1'b0;
      uop_ready_i = 1'b0; resp_valid_i = 1'b0; resp_exc_i = 1'b0;

      //            nf vl vs vd  ld exc idle uops exc vst
      vecs[0] = '{2, 4, 0,  3, 1, -1, 0,  12, 0, 4};
      vecs[1] = '{1, 3, 0,  8, 0,  3, 0,  -1, 1, 1};
      vecs[2] = '{0, 5, 5,  0, 1, -1, 4,   0, 0, 5};
      vecs[3] = '{1, 2, 0, 31, 0, -1, 0,   4, 0, 2};
      vecs[4] = '{7, 3, 2, 28, 1, -1, 0,   8, 0, 3};
      vecs[5] = '{0, 6, 7,  0, 0, -1, 3,   0, 0, 6};
      vecs[6] = '{0, 4, 1,  0, 1,  0, 0,  -1, 1, 1};

      repeat (3) @(negedge clk_i);
      #1;
      chk_reset_outputs();
      rst_ni = 1'b1;
      @(negedge clk_i);
      #1;
      chk_reset_outputs();
      $display("reset: outputs at reset values");

      for (int i = 0; i < 7; i++) run_op(vecs[i], i);

      // Window limit: responses withheld, exactly 4 issues, then one more
      // after a single response.
      start_op(7, 4, 0, 0, 1);
      uop_ready_i = 1'b1;
      fires = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         seg_valid_i = 1'b0;
         #1;
         if (uop_valid_o && uop_ready_i) fires++;
      end
      chk("window_fires", fires, 4);
      chk("window_valid_low", uop_valid_o, 0);
      fires = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_i);
         resp_valid_i = (c == 0);
         resp_exc_i   = 1'b0;
         #1;
         if (uop_valid_o && uop_ready_i) fires++;
      end
      chk("window_refill", fires, 1);
      $display("window: 4 issues held, 1 issue after one response");
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Abandon an op by reset with 3 micro-ops outstanding.
      start_op(1, 4, 0, 5, 0);
      fires = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         seg_valid_i = 1'b0;
         uop_ready_i = (fires < 3);
         #1;
         if (uop_valid_o && uop_ready_i) fires++;
      end
      chk("pre_reset_fires", fires, 3);
      chk("stall_valid", uop_valid_o, 1);
      chk("stall_vstart", uop_vstart_o, 1);
      chk("stall_vd", uop_vd_o, 6);
      @(negedge clk_i);
      #1;
      chk("stall_hold_vstart", uop_vstart_o, 1);
      chk("stall_hold_vd", uop_vd_o, 6);
      chk("busy_mid_op", busy_o, 1);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk_reset_outputs();
      @(negedge clk_i);
      rst_ni = 1'b1;
      ara_idle_i = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         #1;
         if (done_valid_o) done_cnt++;
      end
      chk("no_done_after_reset", done_cnt, 0);
      $display("reset mid-op: outputs cleared, no done pulse");

      // Fresh op after the flush must behave normally.
      run_op(vecs[3], 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
